// File: rtl/mips_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: data width, op codes and FSM states.
package mips_pkg;
    localparam int DW = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_e;
endpackage

// File: rtl/hilo_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per i_step.
// Operands arrive as magnitudes; sign fix-up is left to the caller.
module hilo_divider #(
    parameter int DW = mips_pkg::DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [DW-1:0] i_dividend,
    input  logic [DW-1:0] i_divisor,
    output logic [DW-1:0] o_quot,
    output logic [DW-1:0] o_rem
);
    logic [DW-1:0] r_quot, r_rem, r_dvs;
    logic [DW:0]   w_shift, w_diff;

    // The dividend shifts out of r_quot while quotient bits shift in behind it.
    assign w_shift = {r_rem, r_quot[DW-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_load) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (i_step) begin
            r_rem  <= w_diff[DW] ? w_shift[DW-1:0] : w_diff[DW-1:0];
            r_quot <= {r_quot[DW-2:0], ~w_diff[DW]};
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply (and optional divide) unit with MTHI/MTLO writes.
// Divider present only when HILO_MULDIV_DIV_EN is defined; otherwise DIV/DIVU are NOPs.
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int DW = mips_pkg::DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);
    localparam int CW = $clog2(DW);

    state_e          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_acc, w_prod, w_res;
    logic [DW-1:0]   r_mcand, r_hi, r_lo;
    logic [DW:0]     w_mul_sum;
    logic            r_neg, r_done;
    logic            w_idle_start, w_start_mul, w_last, w_mul_step, w_fix_wr;

    function automatic logic [DW-1:0] f_mag(input logic [DW-1:0] v, input logic sgn);
        return (sgn && v[DW-1]) ? -v : v;
    endfunction

    assign w_idle_start = (r_state == ST_IDLE) && start;
    assign w_start_mul  = w_idle_start && (op == OP_MULT || op == OP_MULTU);
    assign w_last       = (r_cnt == CW'(DW-1));
    // r_acc = {partial product, remaining multiplier bits}; the carry lands in bit 2*DW-1.
    assign w_mul_sum    = {1'b0, r_acc[2*DW-1:DW]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
    assign w_prod       = r_neg ? -r_acc : r_acc;

`ifdef HILO_MULDIV_DIV_EN
    logic          r_is_div, r_neg_q, r_neg_r, w_start_div, w_div_step;
    logic [DW-1:0] w_quot, w_rem;

    assign w_start_div = w_idle_start && (op == OP_DIV || op == OP_DIVU);
    assign w_res = r_is_div ? {(r_neg_r ? -w_rem : w_rem), (r_neg_q ? -w_quot : w_quot)} : w_prod;

    hilo_divider #(.DW(DW)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_start_div),
        .i_step    (w_div_step),
        .i_dividend(f_mag(rs_val, ~op[0])),
        .i_divisor (f_mag(rt_val, ~op[0])),
        .o_quot    (w_quot),
        .o_rem     (w_rem)
    );
`else
    assign w_res = w_prod;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_mul) w_next = ST_MUL;
`ifdef HILO_MULDIV_DIV_EN
                else if (w_start_div) w_next = (rt_val == '0) ? ST_FIX : ST_DIV;
`endif
            end
            ST_MUL: if (abort) w_next = ST_IDLE; else if (w_last) w_next = ST_FIX;
`ifdef HILO_MULDIV_DIV_EN
            ST_DIV: if (abort) w_next = ST_IDLE; else if (w_last) w_next = ST_FIX;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        w_mul_step = 1'b0;
        w_fix_wr   = 1'b0;
`ifdef HILO_MULDIV_DIV_EN
        w_div_step = 1'b0;
`endif
        case (r_state)
            ST_MUL: begin busy = 1'b1; w_mul_step = 1'b1; end
`ifdef HILO_MULDIV_DIV_EN
            ST_DIV: begin busy = 1'b1; w_div_step = 1'b1; end
`endif
            ST_FIX: begin busy = 1'b1; w_fix_wr = ~abort; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_idle_start) begin
                case (op)
                    OP_MTHI: r_hi <= rs_val;
                    OP_MTLO: r_lo <= rs_val;
                    OP_MULT, OP_MULTU: begin
                        r_acc   <= {{DW{1'b0}}, f_mag(rs_val, ~op[0])};
                        r_mcand <= f_mag(rt_val, ~op[0]);
                        r_neg   <= ~op[0] & (rs_val[DW-1] ^ rt_val[DW-1]);
                        r_cnt   <= '0;
`ifdef HILO_MULDIV_DIV_EN
                        r_is_div <= 1'b0;
`endif
                    end
`ifdef HILO_MULDIV_DIV_EN
                    OP_DIV, OP_DIVU: begin
                        r_cnt   <= '0;
                        r_neg_q <= ~op[0] & (rs_val[DW-1] ^ rt_val[DW-1]);
                        r_neg_r <= ~op[0] & rs_val[DW-1];
                        // Divide by zero reuses the product path: {hi,lo} = {rs_val, all-ones}.
                        if (rt_val == '0) begin
                            r_acc    <= {rs_val, {DW{1'b1}}};
                            r_neg    <= 1'b0;
                            r_is_div <= 1'b0;
                        end else begin
                            r_is_div <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            if (w_mul_step) begin
                r_acc <= {w_mul_sum, r_acc[DW-1:1]};
                r_cnt <= r_cnt + CW'(1);
            end
`ifdef HILO_MULDIV_DIV_EN
            if (w_div_step) r_cnt <= r_cnt + CW'(1);
`endif
            if (w_fix_wr) begin
                r_hi   <= w_res[2*DW-1:DW];
                r_lo   <= w_res[DW-1:0];
                r_done <= 1'b1;
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: scoreboarded HI/LO results, latency, abort and reset checks.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort, busy, done;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val, hi, lo;

    typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    hilo_muldiv_unit #(.DW(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts done pulses over a window where none may occur.
    task automatic quiet(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int   n;
        exp_t e;
        sb.push_back('{hi: ehi, lo: elo});
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        chk($sformatf("%s_busy", tag), busy, 1);
        while (!done && n < 100) begin tick(); n++; end
        chk($sformatf("%s_lat", tag), n, elat);
        e = sb.pop_front();
        chk($sformatf("%s_hi", tag), hi, e.hi);
        chk($sformatf("%s_lo", tag), lo, e.lo);
        chk($sformatf("%s_busy_end", tag), busy, 0);
        m_hi = e.hi; m_lo = e.lo;
        tick();
        chk($sformatf("%s_pulse", tag), done, 0);
    endtask

    initial begin
        logic [31:0]        a, b;
        logic signed [63:0] sa, sb64;
        logic [63:0]        p;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'b0; rs_val = '0; rt_val = '0;
        tick(); tick();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        tick();

        // MTHI then MTLO on consecutive cycles
        op = 3'b100; rs_val = 32'h12345678; start = 1'b1;
        tick();
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", busy, 0);
        op = 3'b101; rs_val = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", busy, 0);
        chk("mtlo_done", done, 0);
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

        // NOP op and abort-in-idle have no effect
        op = 3'b111; rs_val = 32'h55555555; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("nop_busy", busy, 0);
        chk("nop_hi", hi, m_hi);
        chk("nop_lo", lo, m_lo);

        do_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
        do_op("mult_neg3x7", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 34);
        do_op("mult_min_x2", 3'b000, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 34);
        do_op("mult_negneg", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34);

        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            if (i[0]) begin
                sa = $signed(a); sb64 = $signed(b); p = sa * sb64;
                do_op($sformatf("mult_rnd%0d", i), 3'b000, a, b, p[63:32], p[31:0], 34);
            end else begin
                p = {32'b0, a} * {32'b0, b};
                do_op($sformatf("multu_rnd%0d", i), 3'b001, a, b, p[63:32], p[31:0], 34);
            end
        end

        // Abort mid-multiply; a start while busy is ignored
        op = 3'b001; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        op = 3'b100; rs_val = 32'hDEADBEEF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_hi", hi, m_hi);
        repeat (4) tick();
        chk("abort_busy_pre", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        quiet("abort_quiet", 40);
        chk("abort_hi", hi, m_hi);
        chk("abort_lo", lo, m_lo);

        // Abort coinciding with the FIX write edge
        op = 3'b001; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        chk("fixab_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("fixab_done", done, 0);
        chk("fixab_busy_end", busy, 0);
        quiet("fixab_quiet", 5);
        chk("fixab_hi", hi, m_hi);
        chk("fixab_lo", lo, m_lo);

`ifdef HILO_MULDIV_DIV_EN
        do_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
        do_op("divu_by0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 2);
        do_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);
        do_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        do_op("div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34);
        op = 3'b011; rs_val = 32'd1000; rt_val = 32'd3;
`else
        // Without the divider, DIV/DIVU behave as NOPs
        op = 3'b010; rs_val = 32'hFFFFFFF9; rt_val = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("divnop_busy", busy, 0);
        quiet("divnop_quiet", 40);
        chk("divnop_hi", hi, m_hi);
        chk("divnop_lo", lo, m_lo);
        op = 3'b001; rs_val = 32'd1000; rt_val = 32'd3;
`endif

        // Reset at cycle 20 of an in-flight operation
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        reset_n = 1'b0;
        #1;
        chk("mrst_hi", hi, 0);
        chk("mrst_lo", lo, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        tick(); tick();
        reset_n = 1'b1;
        quiet("mrst_quiet", 40);
        chk("mrst_hi_after", hi, 0);
        chk("mrst_lo_after", lo, 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand and HI/LO register width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request strobe, sampled only when idle.
REQ-005 SHALL have port op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP.
REQ-006 SHALL have port rs_val  input  DW  first operand, which is the dividend or the MTHI/MTLO source.
REQ-007 SHALL have port rt_val  input  DW  second operand, which is the divisor.
REQ-008 SHALL have port abort  input  1  cancels an in-flight operation (pipeline flush).
REQ-009 SHALL have port busy  output  1  high while a multiply or divide is iterating.
REQ-010 SHALL have port done  output  1  one-cycle pulse on the cycle HI/LO take a mult/div result.
REQ-011 SHALL have ports hi and lo  output  DW each  architectural HI/LO registers, which feed the HI/LO read muxes.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX; it leaves IDLE only on start with a mult/div op.
REQ-013 SHALL, on start+MTHI or start+MTLO in IDLE, write rs_val into hi or lo at that edge, with no busy and no done.
REQ-014 SHALL, on start+MULT/MULTU, latch operand magnitudes (absolute values for MULT) and sign, enter MUL, and assert busy from the next cycle.
REQ-015 SHALL run a radix-2 shift-add multiply for exactly DW cycles in MUL, then one FIX cycle; in FIX it negates the 2*DW product when the signs differed.
REQ-016 SHALL write the product upper half to hi and lower half to lo at the end of FIX, pulse done, and deassert busy in the same cycle, for a total latency of DW+2 edges from start.
REQ-017 SHALL, on start+DIV/DIVU with rt_val nonzero, run a restoring divide for DW cycles in DIV, then FIX: quotient negated if operand signs differ (DIV only), remainder takes dividend sign; lo=quotient, hi=remainder.
REQ-018 SHALL, on divide with rt_val==0, skip DIV, go straight to FIX, and write lo=all-ones and hi=rs_val (latency 2).
REQ-019 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0 without error.
REQ-020 SHALL ignore start while busy; the operands and op of the ignored request are discarded.
REQ-021 SHALL, on abort while busy, return to IDLE next edge with hi/lo unchanged and no done pulse; abort in IDLE has no effect.
REQ-022 SHALL, when abort and the FIX completion edge coincide, give abort priority, so no write occurs.
REQ-023 SHALL treat a NOP op with start as a no-op with no state change.

Reset
REQ-024 SHALL, while reset_n is low, asynchronously force state=IDLE, hi=0, lo=0, busy=0, done=0, and clear the internal accumulators.
REQ-025 SHALL, on reset mid-operation, discard the operation and never write its result after reset release.

Configuration
REQ-026 SHALL compile in the divider and the DIV state only when HILO_MULDIV_DIV_EN is defined.
REQ-027 SHALL, without HILO_MULDIV_DIV_EN, treat DIV/DIVU as NOP: no busy, no done, hi/lo unchanged.

Structure
REQ-028 SHALL take the op encodings, the FSM state enum and DW from the shared package mips_pkg.
REQ-029 SHALL place the shift-subtract divide datapath in one sub-module, hilo_divider, instantiated only under HILO_MULDIV_DIV_EN.

Verification
REQ-030 SHALL check: MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001, done for 1 cycle.
REQ-031 SHALL check: MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 SHALL check: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> lo=0xFFFFFFFF, hi=100 after 2 edges.
REQ-033 SHALL check: MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edge, busy stays 0.
REQ-034 SHALL check: MULTU 3*5 started, abort at cycle 10 -> hi/lo keep their prior values, no done; a start during busy is ignored.
REQ-035 SHALL check: reset_n low at cycle 20 of a DIVU -> all outputs 0 immediately, no later done.
